// File: rtl/sq_out_normalizer.sv
// Converts the redundant-form square result into a plain binary integer by carry-propagating
// ELEMS_PER_CYCLE coefficients per cycle. No modular reduction is performed.
module sq_out_normalizer #(
  parameter int MOD_LEN               = 1024,
  parameter int WORD_LEN              = 16,
  parameter int BIT_LEN               = 17,
  parameter int REDUNDANT_ELEMENTS    = 2,
  parameter int NONREDUNDANT_ELEMENTS = MOD_LEN / WORD_LEN,
  parameter int NUM_ELEMENTS          = REDUNDANT_ELEMENTS + NONREDUNDANT_ELEMENTS,
  parameter int SQ_OUT_BITS           = NUM_ELEMENTS * WORD_LEN * 2,
  parameter int ELEMS_PER_CYCLE       = 6,
  parameter int OUT_LEN               = NUM_ELEMENTS * WORD_LEN + 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SQ_OUT_BITS-1:0] sq_in_bus,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_LEN-1:0]     result,
  output logic                   pad_err
);

  localparam int SLOT    = 2 * WORD_LEN;
  localparam int STEPS   = NUM_ELEMENTS / ELEMS_PER_CYCLE;
  localparam int CNT_W   = $clog2(STEPS + 1);
  localparam int GRP_W   = ELEMS_PER_CYCLE * WORD_LEN;
  localparam int WORDS_W = NUM_ELEMENTS * WORD_LEN;
  localparam int SUM_W   = WORD_LEN + 2;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [SQ_OUT_BITS-1:0] coef_q;
  logic [WORDS_W-1:0]     words_q;
  logic [1:0]             top_q;
  logic [1:0]             carry_q;
  logic [CNT_W-1:0]       step_q;
  logic                   pad_q;

  logic                   pad_in;
  logic [GRP_W-1:0]       grp_sum;
  logic [1:0]             grp_carry;
  logic [SUM_W-1:0]       s_tmp;
  logic [1:0]             c_tmp;
  logic                   last_step;

  assign last_step = (step_q == CNT_W'(STEPS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Any nonzero bit in a slot's padding region flags the whole capture.
  always_comb begin
    pad_in = 1'b0;
    for (int j = 0; j < NUM_ELEMENTS; j++)
      pad_in = pad_in | (|sq_in_bus[j*SLOT+BIT_LEN +: SLOT-BIT_LEN]);
  end

  // Lowest ELEMS_PER_CYCLE slots of the shifting capture register are folded this cycle.
  always_comb begin
    grp_sum = '0;
    s_tmp   = '0;
    c_tmp   = carry_q;
    for (int i = 0; i < ELEMS_PER_CYCLE; i++) begin
      s_tmp = SUM_W'(coef_q[i*SLOT +: BIT_LEN]) + SUM_W'(c_tmp);
      grp_sum[i*WORD_LEN +: WORD_LEN] = s_tmp[WORD_LEN-1:0];
      c_tmp = s_tmp[WORD_LEN +: 2];
    end
    grp_carry = c_tmp;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coef_q  <= '0;
      words_q <= '0;
      top_q   <= '0;
      carry_q <= '0;
      step_q  <= '0;
      pad_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          coef_q  <= sq_in_bus;
          carry_q <= '0;
          step_q  <= '0;
          top_q   <= '0;
          pad_q   <= pad_in;
        end
        BUSY: if (last_step) begin
          top_q <= carry_q;
        end else begin
          // Words enter at the top and shift down; after STEPS shifts word 0 sits at bit 0.
          words_q <= {grp_sum, words_q[WORDS_W-1:GRP_W]};
          coef_q  <= coef_q >> (ELEMS_PER_CYCLE * SLOT);
          carry_q <= grp_carry;
          step_q  <= step_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result  = {top_q, words_q};
  assign pad_err = pad_q;

endmodule

// File: tb/tb_sq_out_normalizer.sv
// Bench for sq_out_normalizer: directed corner cases plus random buses checked against
// a big-integer sum reference.
module tb_sq_out_normalizer;
  localparam int NUM_ELEMENTS = 66;
  localparam int SLOT         = 32;
  localparam int SQ_OUT_BITS  = NUM_ELEMENTS * SLOT;
  localparam int OUT_LEN      = NUM_ELEMENTS * 16 + 2;
  localparam int LAT          = 12;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [SQ_OUT_BITS-1:0] sq_in_bus;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_LEN-1:0]     result;
  logic                   pad_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sq_out_normalizer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sq_in_bus(sq_in_bus), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .pad_err(pad_err)
  );

  // Reference: value = sum of the low 17 bits of each slot weighted by 2^(16j).
  function automatic logic [OUT_LEN-1:0] ref_sum(input logic [SQ_OUT_BITS-1:0] bus);
    logic [OUT_LEN-1:0] acc, term;
    acc = '0;
    for (int j = 0; j < NUM_ELEMENTS; j++) begin
      term = OUT_LEN'(bus[j*SLOT +: 17]);
      acc  = acc + (term << (16 * j));
    end
    return acc;
  endfunction

  function automatic logic ref_pad(input logic [SQ_OUT_BITS-1:0] bus);
    for (int j = 0; j < NUM_ELEMENTS; j++)
      if (bus[j*SLOT+17 +: 15] != 15'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [SQ_OUT_BITS-1:0] fill(input logic [31:0] v);
    logic [SQ_OUT_BITS-1:0] b;
    for (int j = 0; j < NUM_ELEMENTS; j++) b[j*SLOT +: 32] = v;
    return b;
  endfunction

  function automatic logic [SQ_OUT_BITS-1:0] rand_bus(input int pad_pct);
    logic [SQ_OUT_BITS-1:0] b;
    logic [31:0] w;
    for (int j = 0; j < NUM_ELEMENTS; j++) begin
      w = $urandom;
      if ($urandom_range(99) >= pad_pct) w = w & 32'h0001FFFF;
      if ($urandom_range(3) == 0) w = 32'h0001FFFF;
      b[j*SLOT +: 32] = w;
    end
    return b;
  endfunction

  // Locates the first 64-bit chunk where two results differ, for compact failure lines.
  function automatic int diff_chunk(input logic [OUT_LEN-1:0] a, input logic [OUT_LEN-1:0] b);
    logic [1087:0] x;
    x = 1088'(a ^ b);
    for (int i = 0; i < 17; i++) if (x[i*64 +: 64] != 64'd0) return i;
    return 0;
  endfunction

  function automatic logic [63:0] chunk(input logic [OUT_LEN-1:0] a, input int k);
    logic [1087:0] x;
    x = 1088'(a);
    return x[k*64 +: 64];
  endfunction

  task automatic start(input logic [SQ_OUT_BITS-1:0] bus, output bit ok);
    int n = 0;
    @(negedge clk);
    sq_in_bus = bus;
    in_valid  = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sq_in_bus = '0;
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: nonzero"); end
    checks++; if (pad_err !== 1'b0) begin errors++; $display("FAIL reset_pad_err: got %b want 0", pad_err); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Runs one full conversion and checks latency, value, pad flag and handshake state.
  task automatic test_convert(input string name, input logic [SQ_OUT_BITS-1:0] bus,
                              input logic [OUT_LEN-1:0] want);
    bit ok;
    int lat, k;
    start(bus, ok);
    wait_done(lat);
    if (!ok) lat = -1;
    checks++; if (lat != LAT) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, lat, LAT); end
    checks++;
    if (result !== want) begin
      errors++; k = diff_chunk(result, want);
      $display("FAIL %s_result: chunk %0d got %h want %h", name, k, chunk(result, k), chunk(want, k));
    end
    checks++; if (pad_err !== ref_pad(bus)) begin errors++; $display("FAIL %s_pad_err: got %b want %b", name, pad_err, ref_pad(bus)); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_in_ready_done: got %b want 0", name, in_ready); end
    release_out();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_out_valid_after: got %b want 0", name, out_valid); end
  endtask

  task automatic test_patterns();
    logic [SQ_OUT_BITS-1:0] b;
    logic [OUT_LEN-1:0] w;
    w = {2'b00, {(OUT_LEN-2){1'b1}}};
    test_convert("all_ffff", fill(32'h0000FFFF), w);
    test_convert("all_max", fill(32'h0001FFFF), ref_sum(fill(32'h0001FFFF)));
    b = '0; b[31:0] = 32'h00010000;
    w = '0; w[16] = 1'b1;
    test_convert("coef0_carry", b, w);
    b = '0; b[65*SLOT +: 32] = 32'h0001FFFF;
    w = '0; w[1040 +: 17] = 17'h1FFFF;
    test_convert("coef65_top", b, w);
    checks++; if (result[OUT_LEN-1 -: 2] !== 2'b01) begin errors++; $display("FAIL coef65_topbits: got %b want 01", result[OUT_LEN-1 -: 2]); end
    b = '0; b[10*SLOT +: 32] = 32'h80000001;
    w = '0; w[160] = 1'b1;
    test_convert("pad_slot10", b, w);
    b = '0; b[10*SLOT +: 32] = 32'h00000001;
    test_convert("pad_clean", b, w);
  endtask

  task automatic test_backpressure();
    logic [SQ_OUT_BITS-1:0] a, b;
    logic [OUT_LEN-1:0] held;
    bit ok;
    int lat, bad;
    a = rand_bus(0);
    b = rand_bus(10);
    start(a, ok);
    wait_done(lat);
    checks++; if (!ok || lat != LAT) begin errors++; $display("FAIL bp_latency: got %0d want %0d", lat, LAT); end
    held = result;
    checks++; if (held !== ref_sum(a)) begin errors++; $display("FAIL bp_first_result: value differs from reference"); end
    @(negedge clk);
    sq_in_bus = b;
    in_valid  = 1'b1;
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d disturbed cycles, want 0", bad); end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_to_idle: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_capture: in_ready=%b want 0", in_ready); end
    wait_done(lat);
    checks++; if (lat != LAT) begin errors++; $display("FAIL bp_second_latency: got %0d want %0d", lat, LAT); end
    checks++; if (result !== ref_sum(b) || pad_err !== ref_pad(b)) begin errors++; $display("FAIL bp_second_result: pad_err=%b want %b or value differs", pad_err, ref_pad(b)); end
    release_out();
  endtask

  task automatic test_reset_mid();
    logic [SQ_OUT_BITS-1:0] b;
    bit ok;
    b = fill(32'h0001FFFF);
    b[3*SLOT +: 32] = 32'h0F01FFFF;
    start(b, ok);
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midreset_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    checks++; if (result !== '0 || pad_err !== 1'b0) begin errors++; $display("FAIL midreset_out: pad_err=%b want 0 or result nonzero", pad_err); end
    @(negedge clk);
    reset = 1'b1;
    b = rand_bus(0);
    test_convert("after_reset", b, ref_sum(b));
  endtask

  task automatic test_random();
    logic [SQ_OUT_BITS-1:0] b;
    for (int t = 0; t < 10; t++) begin
      b = rand_bus(3);
      test_convert($sformatf("rand%0d", t), b, ref_sum(b));
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
